etapa_id_ex: RTL and testbench

ID/EX pipeline register of the processor, with load-use hazard detection and bubble insertion. It captures decoded operands and control from the ID stage. It drives the `*_exe` signals consumed by the forwarding unit and the EX datapath (`RP_exe`, `RS_exe`, `SelOp_A_exe`, `SelOp_B_exe`, `prohib_exe`). When a load in EX feeds the instruction in ID, it inserts `CARGA_BURBUJAS` bubbles, because the MEM/WB forwarding paths cannot cover load data. It also flushes on a taken branch and freezes on an external stall.

---
 rtl/etapa_id_ex.sv | 151 +++++++++++++++
 tb/tb_etapa_id_ex.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and external freeze.
// Optional macro DETECCION_CARGA_EN builds the load-use detector and its FSM/counter.
module etapa_id_ex #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 4,
  parameter int CARGA_BURBUJAS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rp,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rg,
  input  logic              id_usa_rp,
  input  logic              id_usa_rs,
  input  logic              id_prohib,
  input  logic              id_lee_mem,
  input  logic [1:0]        id_selop_a,
  input  logic [1:0]        id_selop_b,
  input  logic [DATA_W-1:0] id_dato_a,
  input  logic [DATA_W-1:0] id_dato_b,
  input  logic [DATA_W-1:0] id_inm,
  input  logic [7:0]        id_ctrl,
  input  logic              salto_tomado,
  input  logic              stall_ext,
  output logic              valid_exe,
  output logic              prohib_exe,
  output logic              lee_mem_exe,
  output logic [REG_W-1:0]  RP_exe,
  output logic [REG_W-1:0]  RS_exe,
  output logic [REG_W-1:0]  RG_exe,
  output logic [1:0]        SelOp_A_exe,
  output logic [1:0]        SelOp_B_exe,
  output logic [DATA_W-1:0] dato_a_exe,
  output logic [DATA_W-1:0] dato_b_exe,
  output logic [DATA_W-1:0] inm_exe,
  output logic [7:0]        ctrl_exe,
  output logic              stall_id
);

  logic cargar;
  logic burbuja;

`ifdef DETECCION_CARGA_EN
  // estado | meaning
  // LIBRE  | normal capture; load-use hazard checked against EX
  // ESPERA | bubbles pending while the load drains, counted by cnt
  typedef enum logic {LIBRE = 1'b0, ESPERA = 1'b1} estado_t;

  localparam logic [2:0] CNT_INI = 3'(CARGA_BURBUJAS - 1);

  estado_t    estado, estado_n;
  logic [2:0] cnt, cnt_n;
  logic       riesgo;

  assign riesgo = valid_exe & lee_mem_exe & ~prohib_exe & id_valid &
                  ((id_usa_rp & (RG_exe == id_rp)) | (id_usa_rs & (RG_exe == id_rs)));

  always_ff @(posedge clk) begin
    estado <= estado_n;
    cnt    <= cnt_n;
  end

  always_comb begin
    estado_n = estado;
    cnt_n    = cnt;
    cargar   = 1'b0;
    burbuja  = 1'b0;
    stall_id = stall_ext;
    if (rst) begin
      burbuja  = 1'b1;
      estado_n = LIBRE;
      cnt_n    = 3'd0;
    end else if (stall_ext) begin
      cargar = 1'b0;
    end else if (salto_tomado) begin
      burbuja  = 1'b1;
      estado_n = LIBRE;
      cnt_n    = 3'd0;
    end else if (estado == ESPERA) begin
      // riesgo is deliberately ignored here; the counter alone tracks the load
      burbuja  = 1'b1;
      stall_id = 1'b1;
      cnt_n    = cnt - 3'd1;
      if (cnt == 3'd1) estado_n = LIBRE;
    end else if (riesgo) begin
      burbuja  = 1'b1;
      stall_id = 1'b1;
      cnt_n    = CNT_INI;
      estado_n = (CNT_INI != 3'd0) ? ESPERA : LIBRE;
    end else if (id_valid) begin
      cargar = 1'b1;
    end else begin
      burbuja = 1'b1;
    end
  end
`else
  // Without detection, load-use spacing is left to software.
  logic unused_cfg;
  assign unused_cfg = &{1'b0, id_usa_rp, id_usa_rs, 3'(CARGA_BURBUJAS)};
  assign stall_id   = stall_ext;

  always_comb begin
    cargar  = 1'b0;
    burbuja = 1'b0;
    if (rst) begin
      burbuja = 1'b1;
    end else if (stall_ext) begin
      cargar = 1'b0;
    end else if (salto_tomado) begin
      burbuja = 1'b1;
    end else if (id_valid) begin
      cargar = 1'b1;
    end else begin
      burbuja = 1'b1;
    end
  end
`endif

  // Neither cargar nor burbuja means hold (external freeze).
  always_ff @(posedge clk) begin
    if (burbuja) begin
      valid_exe   <= 1'b0;
      prohib_exe  <= 1'b1;
      lee_mem_exe <= 1'b0;
      RP_exe      <= '0;
      RS_exe      <= '0;
      RG_exe      <= '0;
      SelOp_A_exe <= 2'b00;
      SelOp_B_exe <= 2'b00;
      dato_a_exe  <= '0;
      dato_b_exe  <= '0;
      inm_exe     <= '0;
      ctrl_exe    <= 8'h00;
    end else if (cargar) begin
      valid_exe   <= id_valid;
      prohib_exe  <= id_prohib;
      lee_mem_exe <= id_lee_mem;
      RP_exe      <= id_rp;
      RS_exe      <= id_rs;
      RG_exe      <= id_rg;
      SelOp_A_exe <= id_selop_a;
      SelOp_B_exe <= id_selop_b;
      dato_a_exe  <= id_dato_a;
      dato_b_exe  <= id_dato_b;
      inm_exe     <= id_inm;
      ctrl_exe    <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_etapa_id_ex.sv
// Scoreboard bench for etapa_id_ex; expectations follow DETECCION_CARGA_EN when defined.
module tb_etapa_id_ex;

  localparam int CB = 2;

  typedef struct packed {
    logic        valid;
    logic [3:0]  rp;
    logic [3:0]  rs;
    logic [3:0]  rg;
    logic        usa_rp;
    logic        usa_rs;
    logic        prohib;
    logic        lee;
    logic [1:0]  sela;
    logic [1:0]  selb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] inm;
    logic [7:0]  ctrl;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic        prohib;
    logic        lee;
    logic [3:0]  rp;
    logic [3:0]  rs;
    logic [3:0]  rg;
    logic [1:0]  sela;
    logic [1:0]  selb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] inm;
    logic [7:0]  ctrl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_usa_rp, id_usa_rs, id_prohib, id_lee_mem;
  logic [3:0]  id_rp, id_rs, id_rg;
  logic [1:0]  id_selop_a, id_selop_b;
  logic [31:0] id_dato_a, id_dato_b, id_inm;
  logic [7:0]  id_ctrl;
  logic        salto_tomado, stall_ext;
  logic        valid_exe, prohib_exe, lee_mem_exe;
  logic [3:0]  RP_exe, RS_exe, RG_exe;
  logic [1:0]  SelOp_A_exe, SelOp_B_exe;
  logic [31:0] dato_a_exe, dato_b_exe, inm_exe;
  logic [7:0]  ctrl_exe;
  logic        stall_id;

  etapa_id_ex #(.DATA_W(32), .REG_W(4), .CARGA_BURBUJAS(CB)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rp(id_rp), .id_rs(id_rs), .id_rg(id_rg),
    .id_usa_rp(id_usa_rp), .id_usa_rs(id_usa_rs),
    .id_prohib(id_prohib), .id_lee_mem(id_lee_mem),
    .id_selop_a(id_selop_a), .id_selop_b(id_selop_b),
    .id_dato_a(id_dato_a), .id_dato_b(id_dato_b), .id_inm(id_inm),
    .id_ctrl(id_ctrl), .salto_tomado(salto_tomado), .stall_ext(stall_ext),
    .valid_exe(valid_exe), .prohib_exe(prohib_exe), .lee_mem_exe(lee_mem_exe),
    .RP_exe(RP_exe), .RS_exe(RS_exe), .RG_exe(RG_exe),
    .SelOp_A_exe(SelOp_A_exe), .SelOp_B_exe(SelOp_B_exe),
    .dato_a_exe(dato_a_exe), .dato_b_exe(dato_b_exe), .inm_exe(inm_exe),
    .ctrl_exe(ctrl_exe), .stall_id(stall_id)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t bub;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  function automatic in_t ins(input logic v, input logic [3:0] rp, input logic [3:0] rs,
                              input logic [3:0] rg, input logic urp, input logic urs,
                              input logic lee, input logic proh);
    in_t r;
    r.valid  = v;
    r.rp     = rp;
    r.rs     = rs;
    r.rg     = rg;
    r.usa_rp = urp;
    r.usa_rs = urs;
    r.prohib = proh;
    r.lee    = lee;
    r.sela   = 2'($urandom_range(3));
    r.selb   = 2'($urandom_range(3));
    r.a      = $urandom;
    r.b      = $urandom;
    r.inm    = $urandom;
    r.ctrl   = 8'($urandom_range(1, 255));
    return r;
  endfunction

  function automatic exp_t exp_of(input in_t i);
    exp_t e;
    if (!i.valid) return bub;
    e.valid  = 1'b1;
    e.prohib = i.prohib;
    e.lee    = i.lee;
    e.rp     = i.rp;
    e.rs     = i.rs;
    e.rg     = i.rg;
    e.sela   = i.sela;
    e.selb   = i.selb;
    e.a      = i.a;
    e.b      = i.b;
    e.inm    = i.inm;
    e.ctrl   = i.ctrl;
    return e;
  endfunction

  // Drive one cycle, check stall_id before the edge, push expected EX content, pop after.
  task automatic step(input string tag, input in_t i, input logic r, input logic se,
                      input logic sal, input exp_t e, input logic est);
    exp_t got, want;
    rst = r; stall_ext = se; salto_tomado = sal;
    id_valid = i.valid; id_rp = i.rp; id_rs = i.rs; id_rg = i.rg;
    id_usa_rp = i.usa_rp; id_usa_rs = i.usa_rs; id_prohib = i.prohib; id_lee_mem = i.lee;
    id_selop_a = i.sela; id_selop_b = i.selb;
    id_dato_a = i.a; id_dato_b = i.b; id_inm = i.inm; id_ctrl = i.ctrl;
    #1;
    chk({tag, ".stall_id"}, 128'(stall_id), 128'(est));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = '{valid_exe, prohib_exe, lee_mem_exe, RP_exe, RS_exe, RG_exe,
            SelOp_A_exe, SelOp_B_exe, dato_a_exe, dato_b_exe, inm_exe, ctrl_exe};
    want = sb_q.pop_front();
    chk({tag, ".exe"}, 128'(got), 128'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t add3, sub3, inv, ld5, use5, ld7, use7, nors, ldp, or9;
    bub = '{valid: 1'b0, prohib: 1'b1, lee: 1'b0, rp: 4'd0, rs: 4'd0, rg: 4'd0,
            sela: 2'd0, selb: 2'd0, a: 32'd0, b: 32'd0, inm: 32'd0, ctrl: 8'd0};
    add3 = ins(1, 4'd1, 4'd2, 4'd3, 1, 1, 0, 0);
    sub3 = ins(1, 4'd3, 4'd4, 4'd6, 1, 1, 0, 0);
    inv  = ins(0, 4'd5, 4'd5, 4'd5, 1, 1, 1, 0);
    ld5  = ins(1, 4'd0, 4'd0, 4'd5, 0, 0, 1, 0);
    use5 = ins(1, 4'd5, 4'd2, 4'd6, 1, 1, 0, 0);
    ld7  = ins(1, 4'd0, 4'd0, 4'd7, 0, 0, 1, 0);
    use7 = ins(1, 4'd1, 4'd7, 4'd8, 1, 1, 0, 0);
    nors = ins(1, 4'd2, 4'd5, 4'd9, 1, 0, 0, 0);
    ldp  = ins(1, 4'd0, 4'd0, 4'd5, 0, 0, 1, 1);
    or9  = ins(1, 4'd1, 4'd1, 4'd9, 1, 1, 0, 0);

    // reset with a valid instruction presented
    step("rst0", add3, 1, 0, 0, bub, 0);
    step("rst1", add3, 1, 0, 0, bub, 0);
    // plain flow, dependent non-load
    step("flow_add", add3, 0, 0, 0, exp_of(add3), 0);
    step("flow_sub", sub3, 0, 0, 0, exp_of(sub3), 0);
    step("invalid", inv, 0, 0, 0, bub, 0);
    // freeze holds EX and beats a simultaneous flush
    step("pre_frz", sub3, 0, 0, 0, exp_of(sub3), 0);
    step("frz_flush", add3, 0, 1, 1, exp_of(sub3), 1);
    step("post_frz", add3, 0, 0, 0, exp_of(add3), 0);

    // load-use on RP
    step("lu_ld", ld5, 0, 0, 0, exp_of(ld5), 0);
`ifdef DETECCION_CARGA_EN
    for (int k = 0; k < CB; k++) step("lu_bub", use5, 0, 0, 0, bub, 1);
`endif
    step("lu_use", use5, 0, 0, 0, exp_of(use5), 0);
    chk("lu_rp", 128'(RP_exe), 128'(4'd5));

    // load-use on RS
    step("lurs_ld", ld7, 0, 0, 0, exp_of(ld7), 0);
`ifdef DETECCION_CARGA_EN
    for (int k = 0; k < CB; k++) step("lurs_bub", use7, 0, 0, 0, bub, 1);
`endif
    step("lurs_use", use7, 0, 0, 0, exp_of(use7), 0);

    // matching RS that is not actually read
    step("nors_ld", ld5, 0, 0, 0, exp_of(ld5), 0);
    step("nors_use", nors, 0, 0, 0, exp_of(nors), 0);
    // load that does not write back
    step("ldp_ld", ldp, 0, 0, 0, exp_of(ldp), 0);
    step("ldp_use", use5, 0, 0, 0, exp_of(use5), 0);

    // flush in the first waiting cycle
    step("fl_ld", ld5, 0, 0, 0, exp_of(ld5), 0);
`ifdef DETECCION_CARGA_EN
    step("fl_bub", use5, 0, 0, 0, bub, 1);
`else
    step("fl_use", use5, 0, 0, 0, exp_of(use5), 0);
`endif
    step("fl_flush", use5, 0, 0, 1, bub, 0);
    step("fl_next", or9, 0, 0, 0, exp_of(or9), 0);

    // external freeze in the middle of a hazard
    step("fz_ld", ld5, 0, 0, 0, exp_of(ld5), 0);
`ifdef DETECCION_CARGA_EN
    step("fz_bub", use5, 0, 0, 0, bub, 1);
    for (int k = 0; k < 3; k++) step("fz_ext", use5, 0, 1, 0, bub, 1);
    for (int k = 1; k < CB; k++) step("fz_rest", use5, 0, 0, 0, bub, 1);
    step("fz_use", use5, 0, 0, 0, exp_of(use5), 0);
`else
    step("fz_use", use5, 0, 0, 0, exp_of(use5), 0);
    for (int k = 0; k < 3; k++) step("fz_ext", or9, 0, 1, 0, exp_of(use5), 1);
    step("fz_after", inv, 0, 0, 0, bub, 0);
`endif

    // reset while waiting
    step("rw_ld", ld5, 0, 0, 0, exp_of(ld5), 0);
`ifdef DETECCION_CARGA_EN
    step("rw_bub", use5, 0, 0, 0, bub, 1);
`else
    step("rw_use", use5, 0, 0, 0, exp_of(use5), 0);
`endif
    step("rw_rst", use5, 1, 0, 0, bub, 0);
    step("rw_use2", use5, 0, 0, 0, exp_of(use5), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
